// File: rtl/sort_pkg.sv
// Shared definitions for the sort host controller: default sizing and FSM state type.
package sort_pkg;

    localparam int unsigned WORD_SIZE_DEF = 4;
    localparam int unsigned DEPTH_DEF     = 8;
    localparam int unsigned TIMEOUT_DEF   = 1023;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSort,
        StSend,
        StCheck,
        StDone
    } state_e;

endpackage

// File: rtl/sort_order_chk.sv
// Serial non-decreasing checker: one adjacent-pair comparison per enabled cycle over the buffer.
module sort_order_chk
    import sort_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            clr,
    input  logic [DEPTH-1:0][WORD_SIZE-1:0] words,
    output logic                            last,
    output logic                            err
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]        idx_q, idx_d;
    logic                 err_q, err_d;
    logic [WORD_SIZE-1:0] word_a, word_b;

    always_comb begin
        word_a = words[idx_q];
        word_b = words[idx_q + 1'b1];
        last   = en && (idx_q == AW'(DEPTH - 2));

        idx_d = '0;
        if (en && !last) begin
            idx_d = idx_q + 1'b1;
        end

        err_d = err_q;
        if (clr) begin
            err_d = 1'b0;
        end else if (en && (word_a > word_b)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    assign err = err_q;

endmodule

// File: rtl/sort_host_ctrl.sv
// Host-side controller for an external sorter: loads a job, waits for the sort, reads the
// result back and checks that it is non-decreasing.
module sort_host_ctrl
    import sort_pkg::*;
#(
    parameter int unsigned WORD_SIZE = WORD_SIZE_DEF,
    parameter int unsigned DEPTH     = DEPTH_DEF,
    parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [WORD_SIZE-1:0]       wr_data,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [WORD_SIZE-1:0]       rd_data,
    output logic                       Load,
    output logic                       Sort,
    output logic                       Send,
    output logic [WORD_SIZE-1:0]       Data_in,
    input  logic                       Ready,
    input  logic                       Busy,
    input  logic                       Waiting,
    input  logic [WORD_SIZE-1:0]       Data_out,
    output logic                       busy_o,
    output logic                       done,
    output logic                       order_err,
    output logic                       timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    state_e               state_q, state_d;
    logic [AW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        wait_q, wait_d;
    logic                 load_q, load_d;
    logic                 sort_q, sort_d;
    logic                 send_q, send_d;
    logic                 done_q;
    logic                 timeout_err_q, timeout_err_d;
    logic [WORD_SIZE-1:0] data_in_q, data_in_d;
    logic                 job_we;
    logic                 chk_clr;
    logic                 chk_last;

    logic [DEPTH-1:0][WORD_SIZE-1:0] job_mem;
    logic [DEPTH-1:0][WORD_SIZE-1:0] res_mem;

    // The sorter's Busy flag carries no information beyond Sort/Waiting here.
    logic unused_busy;
    assign unused_busy = Busy;

    assign job_we = wr_en && (state_q == StIdle);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wait_d        = wait_q;
        timeout_err_d = timeout_err_q;
        chk_clr       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && Ready) begin
                    state_d       = StLoad;
                    cnt_d         = '0;
                    timeout_err_d = 1'b0;
                    chk_clr       = 1'b1;
                end
            end
            StLoad: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = StSort;
                    cnt_d   = '0;
                    wait_d  = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSort: begin
                // A Waiting sampled on the final allowed cycle still wins over the timeout.
                if (Waiting) begin
                    state_d = StSend;
                    cnt_d   = '0;
                    wait_d  = '0;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    state_d       = StDone;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            StSend: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = StCheck;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCheck: begin
                if (chk_last) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        load_d = (state_d == StLoad);
        sort_d = (state_d == StSort);
        send_d = (state_d == StSend);

        // Forward a same-cycle write so a word written together with start is the one loaded.
        data_in_d = '0;
        if (load_d) begin
            if (job_we && (wr_addr == cnt_d)) begin
                data_in_d = wr_data;
            end else begin
                data_in_d = job_mem[cnt_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            wait_q        <= '0;
            load_q        <= 1'b0;
            sort_q        <= 1'b0;
            send_q        <= 1'b0;
            data_in_q     <= '0;
            done_q        <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            wait_q        <= wait_d;
            load_q        <= load_d;
            sort_q        <= sort_d;
            send_q        <= send_d;
            data_in_q     <= data_in_d;
            done_q        <= (state_q == StDone);
            timeout_err_q <= timeout_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (job_we) begin
            job_mem[wr_addr] <= wr_data;
        end
        if (state_q == StSend) begin
            res_mem[cnt_q] <= Data_out;
        end
    end

    sort_order_chk #(
        .WORD_SIZE (WORD_SIZE),
        .DEPTH     (DEPTH)
    ) u_order_chk (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == StCheck),
        .clr   (chk_clr),
        .words (res_mem),
        .last  (chk_last),
        .err   (order_err)
    );

    assign rd_data     = res_mem[rd_addr];
    assign Load        = load_q;
    assign Sort        = sort_q;
    assign Send        = send_q;
    assign Data_in     = data_in_q;
    assign busy_o      = (state_q != StIdle);
    assign done        = done_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sort_host_ctrl.sv
// Directed bench for sort_host_ctrl with a behavioural sorter model.
module tb_sort_host_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [3:0] wr_data;
    logic [2:0] rd_addr;
    logic [3:0] rd_data;
    logic       Load, Sort, Send;
    logic [3:0] Data_in;
    logic       Ready, Busy, Waiting;
    logic [3:0] Data_out;
    logic       busy_o, done, order_err, timeout_err;

    int n_asserts = 0;
    int n_fail    = 0;

    // sorter model state
    logic [7:0][3:0] mem, outv, fault_v;
    logic [2:0]      ld_idx, snd_idx;
    int              sort_cnt;
    int              mode;
    logic            waiting_r;
    logic            ready_v;

    // per-run observations
    int   lat, first_load, first_sort, first_terr, nload, ndone;
    bit   excl_bad, send_seen;
    logic sort_at_terr;

    logic [7:0][3:0] job1, sorted1, job2, sorted2;

    always #5 clk = ~clk;

    sort_host_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .Load        (Load),
        .Sort        (Sort),
        .Send        (Send),
        .Data_in     (Data_in),
        .Ready       (Ready),
        .Busy        (Busy),
        .Waiting     (Waiting),
        .Data_out    (Data_out),
        .busy_o      (busy_o),
        .done        (done),
        .order_err   (order_err),
        .timeout_err (timeout_err)
    );

    function automatic logic [7:0][3:0] sort8(input logic [7:0][3:0] v);
        logic [7:0][3:0] r;
        logic [3:0]      t;
        r = v;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 7 - i; j++) begin
                if (r[j] > r[j+1]) begin
                    t      = r[j];
                    r[j]   = r[j+1];
                    r[j+1] = t;
                end
            end
        end
        return r;
    endfunction

    // Sorter: captures Load words, raises Waiting after three Sort cycles, streams on Send.
    always @(posedge clk) begin
        if (rst) begin
            ld_idx    <= '0;
            snd_idx   <= '0;
            sort_cnt  <= 0;
            waiting_r <= 1'b0;
        end else begin
            if (Load) begin
                mem[ld_idx] <= Data_in;
                ld_idx      <= ld_idx + 3'd1;
                snd_idx     <= '0;
                sort_cnt    <= 0;
            end
            if (Sort) begin
                ld_idx   <= '0;
                sort_cnt <= sort_cnt + 1;
                if (sort_cnt == 2 && mode != 2) begin
                    waiting_r <= 1'b1;
                    outv      <= (mode == 1) ? fault_v : sort8(mem);
                end
            end
            if (Send) begin
                waiting_r <= 1'b0;
                snd_idx   <= snd_idx + 3'd1;
            end
        end
    end

    assign Ready    = ready_v;
    assign Waiting  = waiting_r;
    assign Busy     = Sort & ~waiting_r;
    assign Data_out = outv[snd_idx];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = 4'(d);
        tick();
        wr_en = 1'b0;
    endtask

    // Pulses start (with whatever write is already set up) and follows the job to done.
    task automatic run_job(input bit poke);
        lat = -1; first_load = -1; first_sort = -1; first_terr = -1;
        nload = 0; ndone = 0; excl_bad = 0; send_seen = 0; sort_at_terr = 1'bx;
        start = 1'b1;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        for (int c = 1; c <= 3000; c++) begin
            if (Load && first_load < 0) first_load = c;
            if (Sort && first_sort < 0) first_sort = c;
            if (timeout_err && first_terr < 0) begin
                first_terr   = c;
                sort_at_terr = Sort;
            end
            if (Load) nload++;
            if (Send) send_seen = 1;
            if (int'(Load) + int'(Sort) + int'(Send) > 1) excl_bad = 1;
            if (!Load && Data_in != 4'd0) excl_bad = 1;
            if (done) begin
                ndone++;
                lat = c;
                break;
            end
            if (poke && Send) begin
                wr_en   = 1'b1;
                wr_addr = 3'd0;
                wr_data = 4'hF;
            end else begin
                wr_en = 1'b0;
            end
            tick();
        end
        wr_en = 1'b0;
        tick();
        if (done) ndone++;
    endtask

    task automatic check_result(input string tag, input logic [7:0][3:0] exp);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1;
            check($sformatf("%s[%0d]", tag, i), 32'(rd_data), 32'(exp[i]));
        end
    endtask

    initial begin
        job1    = {4'd10, 4'd2, 4'd8, 4'd7, 4'd5, 4'd3, 4'd1, 4'd6};
        sorted1 = {4'd10, 4'd8, 4'd7, 4'd6, 4'd5, 4'd3, 4'd2, 4'd1};
        job2    = {4'd8, 4'd3, 4'd4, 4'd9, 4'd5, 4'd1, 4'd13, 4'd11};
        sorted2 = {4'd13, 4'd11, 4'd9, 4'd8, 4'd5, 4'd4, 4'd3, 4'd1};
        fault_v = {4'd13, 4'd11, 4'd9, 4'd8, 4'd4, 4'd5, 4'd3, 4'd1};
        mem     = '0;
        outv    = '0;

        rst = 1'b1; start = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        ready_v = 1'b1; mode = 0;
        tick();
        tick();
        check("reset_flags", 32'({Load, Sort, Send, done, busy_o, order_err, timeout_err}), 0);
        check("reset_data_in", 32'(Data_in), 0);
        rst = 1'b0;
        tick();

        // start while the sorter is not ready is ignored
        ready_v = 1'b0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("not_ready_busy", 32'(busy_o), 0);
        check("not_ready_load", 32'(Load), 0);
        tick();
        check("not_ready_busy2", 32'(busy_o), 0);
        ready_v = 1'b1;

        // job 1: word 0 is rewritten in the same cycle as start
        wr(0, 15);
        for (int i = 1; i < 8; i++) wr(i, int'(job1[i]));
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = job1[0];
        run_job(1'b0);
        check("j1_first_load", 32'(first_load), 1);
        check("j1_nload", 32'(nload), 8);
        check("j1_data_in", 32'(mem), 32'(job1));
        check("j1_latency", 32'(lat), 29);
        check("j1_done_once", 32'(ndone), 1);
        check("j1_exclusive", 32'(excl_bad), 0);
        check("j1_order_err", 32'(order_err), 0);
        check("j1_timeout_err", 32'(timeout_err), 0);
        check("j1_idle", 32'(busy_o), 0);
        check_result("j1_result", sorted1);

        // job 2: faulty sorter output
        for (int i = 0; i < 8; i++) wr(i, int'(job2[i]));
        mode = 1;
        run_job(1'b0);
        check("j2_data_in", 32'(mem), 32'(job2));
        check("j2_latency", 32'(lat), 29);
        check("j2_order_err", 32'(order_err), 1);
        check("j2_timeout_err", 32'(timeout_err), 0);
        check_result("j2_result", fault_v);

        // job 3: sorter never reports Waiting
        mode = 2;
        run_job(1'b0);
        check("j3_terr_delay", 32'(first_terr - first_sort), 1023);
        check("j3_sort_at_terr", 32'(sort_at_terr), 0);
        check("j3_send_never", 32'(send_seen), 0);
        check("j3_done_once", 32'(ndone), 1);
        check("j3_latency", 32'(lat), 1033);
        check("j3_timeout_err", 32'(timeout_err), 1);
        check("j3_order_err", 32'(order_err), 0);
        rd_addr = 3'd3;
        #1;
        check("j3_result_held", 32'(rd_data), 4);

        // reset on the third Load cycle
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_load_c1", 32'(Load), 1);
        tick();
        tick();
        check("rst_load_c3", 32'(Load), 1);
        rst = 1'b1;
        tick();
        check("rst_load_off", 32'(Load), 0);
        check("rst_busy_off", 32'(busy_o), 0);
        check("rst_terr_off", 32'(timeout_err), 0);
        rst = 1'b0;
        tick();

        // full reload; a write during SEND must be dropped
        run_job(1'b1);
        check("j4_nload", 32'(nload), 8);
        check("j4_data_in", 32'(mem), 32'(job2));
        check("j4_latency", 32'(lat), 29);
        check("j4_order_err", 32'(order_err), 0);
        check_result("j4_result", sorted2);

        run_job(1'b0);
        check("j5_job_unchanged", 32'(mem), 32'(job2));
        check("j5_done_once", 32'(ndone), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
